// File: rtl/cp0_count_compare.sv
// ---------------------------------------------------------------------------
// cp0_count_compare
//   CP0 Count/Compare timer. Count is a free-running 32-bit counter and
//   Compare is written by software. When Count is loaded with a value equal
//   to Compare, the registered level `equal` is set. It feeds the TI bit (IP7)
//   of cp0_Cause, and any Compare write clears it.
//
// Configuration macro:
//   CP0_COUNT_HALFRATE_EN - when defined, Count advances every second cycle
//                           (MIPS32 half pipeline clock). A Count write
//                           restarts the phase. When undefined, Count
//                           advances every cycle.
//
// Ports:
//   clk               in   1   system clock
//   rst               in   1   synchronous reset, active-high
//   mtc0_we           in   1   MTC0 write strobe (one cycle, WB stage)
//   cp0_addr          in   7   CP0 register select {rd, sel}
//   mtc0_data         in   32  MTC0 write data
//   cp0_Count_data    out  32  current Count
//   cp0_Compare_data  out  32  current Compare
//   equal             out  1   timer interrupt pending (registered level)
// ---------------------------------------------------------------------------

`ifndef cp0addr_Count
`define cp0addr_Count 7'h24
`endif
`ifndef cp0addr_Compare
`define cp0addr_Compare 7'h2C
`endif

module cp0_count_compare #(
  parameter logic [31:0] COUNT_INIT   = 32'h0000_0000,
  parameter logic [31:0] COMPARE_INIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [6:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic [31:0] cp0_Count_data,
  output logic [31:0] cp0_Compare_data,
  output logic        equal
);

  logic [31:0] count;
  logic [31:0] compare;
  logic        equal_q;

  logic        count_wr;
  logic        compare_wr;
  logic        inc_due;
  logic        count_load;
  logic [31:0] count_next;
  logic        match_set;

  always_comb begin
    count_wr   = mtc0_we && (cp0_addr == `cp0addr_Count);
    compare_wr = mtc0_we && (cp0_addr == `cp0addr_Compare);
  end

`ifdef CP0_COUNT_HALFRATE_EN
  // Phase register. An increment is due only on the odd phase. A Count
  // write forces the phase back to 0, so the first increment lands two
  // cycles after the write.
  logic tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else if (count_wr) begin
      tick <= 1'b0;
    end else begin
      tick <= ~tick;
    end
  end

  always_comb inc_due = tick;
`else
  always_comb inc_due = 1'b1;
`endif

  // A write takes priority over the increment. The match check uses the
  // value being loaded and the Compare value from before this cycle's write.
  always_comb begin
    count_load = count_wr || inc_due;
    count_next = count_wr ? mtc0_data : count + 32'd1;
    match_set  = count_load && (count_next == compare);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= COUNT_INIT;
      compare <= COMPARE_INIT;
      equal_q <= 1'b0;
    end else begin
      if (count_load) begin
        count <= count_next;
      end
      if (compare_wr) begin
        compare <= mtc0_data;
      end
      // Clear beats set when a Compare write coincides with a match.
      if (compare_wr) begin
        equal_q <= 1'b0;
      end else if (match_set) begin
        equal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cp0_Count_data   = count;
    cp0_Compare_data = compare;
    equal            = equal_q;
  end

endmodule

// File: tb/tb_cp0_count_compare.sv
// ---------------------------------------------------------------------------
// tb_cp0_count_compare
//   Directed checks for the CP0 Count/Compare timer. These cover reset
//   values, counting, matches, Compare-write clearing, wrap-around, the
//   Compare-write/match collision, and reset in mid-operation. Expected
//   Count values come from a base value plus elapsed cycles divided by the
//   increment period R (1 at full rate, 2 at half rate).
// ---------------------------------------------------------------------------
module tb_cp0_count_compare;

`ifdef CP0_COUNT_HALFRATE_EN
  localparam int R = 2;
`else
  localparam int R = 1;
`endif

  localparam logic [6:0] A_COUNT   = 7'h24;
  localparam logic [6:0] A_COMPARE = 7'h2C;
  localparam logic [6:0] A_OTHER   = 7'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0_we;
  logic [6:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] cp0_Count_data;
  logic [31:0] cp0_Compare_data;
  logic        equal;

  int vectors    = 0;
  int miscompares = 0;
  int k = 0;
  logic [31:0] base = '0;

  cp0_count_compare #(
    .COUNT_INIT  (32'h0000_0000),
    .COMPARE_INIT(32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mtc0_we         (mtc0_we),
    .cp0_addr        (cp0_addr),
    .mtc0_data       (mtc0_data),
    .cp0_Count_data  (cp0_Count_data),
    .cp0_Compare_data(cp0_Compare_data),
    .equal           (equal)
  );

  always #5 clk = ~clk;

  // Advance n clock edges. Outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    mtc0_we   = 1'b1;
    cp0_addr  = a;
    mtc0_data = d;
    step(1);
    mtc0_we   = 1'b0;
    cp0_addr  = A_OTHER;
    mtc0_data = '0;
  endtask

  // Write Count and restart the elapsed-cycle reference at that write.
  task automatic wr_count(input logic [31:0] d);
    wr(A_COUNT, d);
    base = d;
    k    = 0;
  endtask

  function automatic logic [31:0] exp_count();
    logic [31:0] inc;
    inc = 32'(k / R);
    return base + inc;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mtc0_we   = 1'b0;
    cp0_addr  = A_OTHER;
    mtc0_data = '0;

    // T1 reset and free counting
    step(1);
    rst = 1'b0;
    chk32("reset_count", cp0_Count_data, 32'h0);
    chk32("reset_compare", cp0_Compare_data, 32'hFFFF_FFFF);
    chk1("reset_equal", equal, 1'b0);
    step(10);
    chk32("count_10_cycles", cp0_Count_data, 32'(10 / R));

    // T2 match
    wr_count(32'h10);
    chk32("t2_count_written", cp0_Count_data, 32'h10);
    wr(A_COMPARE, 32'h14);
    chk32("t2_compare_written", cp0_Compare_data, 32'h14);
    chk1("t2_equal_after_cmp_wr", equal, 1'b0);
    step(4 * R - 2);
    chk32("t2_count_pre_match", cp0_Count_data, 32'h13);
    chk1("t2_equal_pre_match", equal, 1'b0);
    step(1);
    chk32("t2_count_match", cp0_Count_data, 32'h14);
    chk1("t2_equal_set", equal, 1'b1);
    step(2 * R);
    chk32("t2_count_post", cp0_Count_data, 32'h16);
    chk1("t2_equal_holds", equal, 1'b1);

    // T3 clear by Compare write, Count unaffected
    wr(A_COMPARE, 32'h100);
    chk1("t3_equal_cleared", equal, 1'b0);
    chk32("t3_compare", cp0_Compare_data, 32'h100);
    chk32("t3_count_continues", cp0_Count_data, exp_count());
    step(4);
    chk32("t3_count_later", cp0_Count_data, exp_count());
    chk1("t3_equal_stays_0", equal, 1'b0);

    // Write to an unrelated address is ignored
    wr(A_OTHER, 32'h0);
    chk32("other_addr_compare", cp0_Compare_data, 32'h100);
    chk32("other_addr_count", cp0_Count_data, exp_count());

    // T4 wrap
    wr_count(32'hFFFF_FFFE);
    wr(A_COMPARE, 32'h1);
    chk1("t4_equal_start", equal, 1'b0);
    step(2 * R - 1);
    chk32("t4_count_zero", cp0_Count_data, 32'h0);
    chk1("t4_equal_at_zero", equal, 1'b0);
    step(R - 1);
    chk32("t4_count_zero_late", cp0_Count_data, 32'h0);
    chk1("t4_equal_zero_late", equal, 1'b0);
    step(1);
    chk32("t4_count_one", cp0_Count_data, 32'h1);
    chk1("t4_equal_on_one", equal, 1'b1);

    // A Count write does not clear a pending equal
    wr_count(32'h40);
    chk32("cnt_wr_value", cp0_Count_data, 32'h40);
    chk1("cnt_wr_keeps_equal", equal, 1'b1);

    // T5 collision: Compare write in the same cycle as a matching increment
    wr(A_COMPARE, 32'h44);
    chk1("t5_equal_cleared", equal, 1'b0);
    step(4 * R - 2);
    chk32("t5_count_pre", cp0_Count_data, 32'h43);
    wr(A_COMPARE, 32'h50);
    chk32("t5_count_hit", cp0_Count_data, 32'h44);
    chk32("t5_compare_new", cp0_Compare_data, 32'h50);
    chk1("t5_collision_no_set", equal, 1'b0);
    step(R);
    chk32("t5_count_after", cp0_Count_data, 32'h45);
    chk1("t5_equal_after", equal, 1'b0);
    wr_count(32'h50);
    chk32("t5_cnt_wr_match_val", cp0_Count_data, 32'h50);
    chk1("t5_cnt_wr_match_eq", equal, 1'b1);

    // T6 reset mid-operation
    wr_count(32'h55);
    chk32("t6_pre_count", cp0_Count_data, 32'h55);
    chk1("t6_pre_equal", equal, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk32("t6_reset_count", cp0_Count_data, 32'h0);
    chk32("t6_reset_compare", cp0_Compare_data, 32'hFFFF_FFFF);
    chk1("t6_reset_equal", equal, 1'b0);
    step(1);
    chk32("t6_count_1cyc", cp0_Count_data, 32'(1 / R));
    step(1);
    chk32("t6_count_2cyc", cp0_Count_data, 32'(2 / R));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
